// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its round-robin helper.
package uart_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_TX_TIMEOUT = 200000;
    localparam int DEF_GAP_CYCLES = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_e;

    // One counter serves both the watchdog and the inter-frame gap.
    function automatic int cnt_width(input int tx_timeout, input int gap_cycles);
        int max_v;
        max_v = (tx_timeout > gap_cycles) ? tx_timeout : gap_cycles;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request after last_grant, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any_req
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int               idx_s;
    logic [IDX_W-1:0] pick_s;
    logic             found_s;

    // Scan upward from the slot after the previous winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        idx_s     = 0;
        pick_s    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = int'(last_grant) + k;
            if (idx_s >= NUM_REQ) begin
                idx_s = idx_s - NUM_REQ;
            end else begin
                idx_s = idx_s;
            end
            pick_s = idx_s[IDX_W-1:0];
            if (!found_s && req[pick_s]) begin
                found_s       = 1'b1;
                grant_idx     = pick_s;
                grant[pick_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers with round-robin grant,
// launch strobe, completion return, watchdog timeout and optional inter-frame gap.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TX_TIMEOUT = DEF_TX_TIMEOUT,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          req_done,
    output logic                        newd,
    output logic [DATA_W-1:0]           dintx,
    input  logic                        donetx,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TX_TIMEOUT, GAP_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam arb_state_e       END_NEXT = (GAP_CYCLES == 0) ? IDLE : GAP;

    arb_state_e          state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    last_grant_r, owner_r, grant_idx_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic [DATA_W-1:0]   dintx_r;
    logic                any_req_s, donetx_q_r, busy_r, rise_s, expire_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s),
        .any_req    (any_req_s)
    );

    // Completion edge, watchdog expiry and pulse outputs decoded from registered state.
    always_comb begin
        rise_s      = donetx && !donetx_q_r;
        expire_s    = (state_r == WAIT_DONE) && !rise_s && (cnt_r == TO_LAST);
        timeout_err = expire_s;
        newd        = (state_r == LAUNCH) && !donetx;
        if ((state_r == IDLE) && rst) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
        if ((state_r == WAIT_DONE) && rise_s) begin
            req_done = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;
        end else begin
            req_done = '0;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) state_nxt_s = LAUNCH;
                else           state_nxt_s = IDLE;
            end
            LAUNCH: begin
                if (donetx) state_nxt_s = LAUNCH;
                else        state_nxt_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (rise_s || expire_s) state_nxt_s = END_NEXT;
                else                    state_nxt_s = WAIT_DONE;
            end
            GAP: begin
                if (cnt_r == GAP_LAST) state_nxt_s = IDLE;
                else                   state_nxt_s = GAP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, shared counter, captured byte and owner bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            last_grant_r <= IDX_W'(NUM_REQ - 1);
            owner_r      <= '0;
            dintx_r      <= '0;
            donetx_q_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
            donetx_q_r <= donetx;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        dintx_r <= req_data[grant_idx_s*DATA_W +: DATA_W];
                        owner_r <= grant_idx_s;
                    end
                end
                LAUNCH: cnt_r <= '0;
                WAIT_DONE: begin
                    if (rise_s || expire_s) begin
                        last_grant_r <= owner_r;
                        cnt_r        <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                GAP:     cnt_r <= cnt_r + CNT_W'(1);
                default: cnt_r <= '0;
            endcase
        end
    end

    assign dintx = dintx_r;
    assign owner = owner_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised frame-level bench for uart_tx_arbiter; two instances cover the no-gap and gap builds.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int TMO_A = 50;
    localparam int GAP_A = 0;
    localparam int TMO_B = 12;
    localparam int GAP_B = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, rst_b, sel;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic            donetx;

    logic [N-1:0]    a_ready, a_done, b_ready, b_done;
    logic            a_newd, a_busy, a_tmo, b_newd, b_busy, b_tmo;
    logic [DW-1:0]   a_dintx, b_dintx;
    logic [1:0]      a_owner, b_owner;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TX_TIMEOUT(TMO_A), .GAP_CYCLES(GAP_A)) dut_a (
        .clk(clk), .rst(rst_a), .req_valid(req_valid), .req_data(req_data),
        .req_ready(a_ready), .req_done(a_done), .newd(a_newd), .dintx(a_dintx),
        .donetx(donetx), .busy(a_busy), .owner(a_owner), .timeout_err(a_tmo)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TX_TIMEOUT(TMO_B), .GAP_CYCLES(GAP_B)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(req_valid), .req_data(req_data),
        .req_ready(b_ready), .req_done(b_done), .newd(b_newd), .dintx(b_dintx),
        .donetx(donetx), .busy(b_busy), .owner(b_owner), .timeout_err(b_tmo)
    );

    wire [N-1:0]  ready_o = sel ? b_ready : a_ready;
    wire [N-1:0]  done_o  = sel ? b_done  : a_done;
    wire          newd_o  = sel ? b_newd  : a_newd;
    wire          busy_o  = sel ? b_busy  : a_busy;
    wire          tmo_o   = sel ? b_tmo   : a_tmo;
    wire [DW-1:0] dintx_o = sel ? b_dintx : a_dintx;
    wire [1:0]    owner_o = sel ? b_owner : a_owner;

    int tests_run    = 0;
    int tests_failed = 0;
    int last_grant_m = N - 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference arbitration: first pending requester after the previous owner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (last + k) % N;
            if (((mask >> idx) & 1) != 0) return idx;
        end
        return 0;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_rst(input logic v);
        if (sel) rst_b = v;
        else     rst_a = v;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  busy_o,  0);
        chk({tag, "_newd"},  newd_o,  0);
        chk({tag, "_ready"}, ready_o, 0);
        chk({tag, "_done"},  done_o,  0);
        chk({tag, "_tmo"},   tmo_o,   0);
        chk({tag, "_dintx"}, dintx_o, 0);
        chk({tag, "_owner"}, owner_o, 0);
    endtask

    task automatic do_reset();
        req_valid = '1;
        donetx    = 1'b0;
        set_rst(1'b0);
        step();
        step();
        #1;
        check_all_zero("rst");
        set_rst(1'b1);
        last_grant_m = N - 1;
    endtask

    // One frame: done_after = cycles from newd to donetx rise (0 = never); abort_at = WAIT cycle to reset in.
    task automatic run_frame(input logic [N-1:0] mask, input logic [N*DW-1:0] data,
                             input int stale, input int done_after, input int abort_at);
        int g, tmo, gap;
        logic [N-1:0] oh;
        logic [DW-1:0] byte_exp;
        tmo = sel ? TMO_B : TMO_A;
        gap = sel ? GAP_B : GAP_A;
        req_valid = mask;
        req_data  = data;
        donetx    = (stale > 0);
        #1;
        g        = rr_pick(mask, last_grant_m);
        oh       = N'(1) << g;
        byte_exp = DW'(data >> (g * DW));
        chk("idle_busy", busy_o, 0);
        chk("idle_done", done_o, 0);
        chk("grant", ready_o, oh);
        step();
        for (int s = 0; s < stale; s++) begin
            #1;
            chk("stale_newd", newd_o, 0);
            chk("stale_ready", ready_o, 0);
            step();
        end
        donetx = 1'b0;
        #1;
        chk("newd", newd_o, 1);
        chk("dintx", dintx_o, byte_exp);
        chk("owner", owner_o, g);
        chk("launch_busy", busy_o, 1);
        for (int k = 0; k < tmo; k++) begin
            step();
            if (k == abort_at) begin
                set_rst(1'b0);
                step();
                #1;
                check_all_zero("abort");
                set_rst(1'b1);
                last_grant_m = N - 1;
                return;
            end
            donetx = (done_after > 0) && (k == done_after - 1);
            #1;
            if (donetx) begin
                chk("done_pulse", done_o, oh);
                chk("done_no_tmo", tmo_o, 0);
                break;
            end else if (k == tmo - 1) begin
                chk("tmo_pulse", tmo_o, 1);
                chk("tmo_no_done", done_o, 0);
            end else begin
                chk("wait_quiet", {done_o, tmo_o, newd_o}, 0);
            end
        end
        last_grant_m = g;
        for (int j = 0; j < gap; j++) begin
            step();
            donetx = 1'b0;
            #1;
            chk("gap_ready", ready_o, 0);
            chk("gap_busy", busy_o, 1);
            chk("gap_done", done_o, 0);
        end
        step();
        donetx = 1'b0;
    endtask

    task automatic rand_frame();
        int tmo, abort;
        tmo   = sel ? TMO_B : TMO_A;
        abort = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, tmo - 1)) : -1;
        run_frame(N'($urandom_range(1, 15)), $urandom, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, tmo + 3)), abort);
    endtask

    initial begin
        #2000000;
        $display("FAIL sim_timeout: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        sel       = 1'b0;
        rst_a     = 1'b0;
        rst_b     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        donetx    = 1'b0;
        do_reset();
        run_frame(4'b0001, 32'h0000_00A5, 0, 20, -1);
        do_reset();
        repeat (5) run_frame(4'b1111, 32'h4433_2211, 0, 3, -1);
        run_frame(4'b1111, 32'h4433_2211, 5, 8, -1);
        run_frame(4'b1111, 32'h4433_2211, 0, 0, -1);
        run_frame(4'b1111, 32'h4433_2211, 0, TMO_A, -1);
        run_frame(4'b1111, 32'h4433_2211, 0, TMO_A - 1, -1);
        run_frame(4'b1111, 32'h4433_2211, 0, 0, 6);
        run_frame(4'b1111, 32'h4433_2211, 0, 4, -1);
        repeat (40) rand_frame();
        rst_a = 1'b0;
        sel   = 1'b1;
        do_reset();
        repeat (3) run_frame(4'b1111, $urandom, 0, 5, -1);
        run_frame(4'b1111, $urandom, 0, 0, -1);
        run_frame(4'b1111, $urandom, 2, TMO_B, -1);
        repeat (40) rand_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
